// File: rtl/hsimple_pkg.sv
// Shared defaults for the hsimple memory-bank family: word/address widths,
// default bank depth, and the rwbar encoding used on the request bus.
package hsimple_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_MEMSIZE = 200000;

  // rwbar encoding: high selects a read, low selects a write.
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

endpackage

// File: rtl/hsimple_ram.sv
// Word array with synchronous write and asynchronous read, plus the range
// check shared by both paths. Out-of-range writes are dropped and
// out-of-range reads return zero.
module hsimple_ram
  import hsimple_pkg::*;
#(
  parameter int MEMSIZE = DEF_MEMSIZE,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              in_range
);

  // Index width covers exactly the populated words; the full address is
  // still compared against MEMSIZE so upper bits never alias into the array.
  localparam int              IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(MEMSIZE);

  logic [DATA_W-1:0] mem_q [MEMSIZE];
  logic [IDX_W-1:0]  idx;

  assign in_range = ({1'b0, addr} < LIMIT);
  assign idx      = addr[IDX_W-1:0];

  // Asynchronous read; zero when the address falls outside the bank.
  always_comb begin
    rdata = '0;
    if (in_range) begin
      rdata = mem_q[idx];
    end
  end

  // Synchronous write, gated by the range check so stray addresses are harmless.
  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem_q[idx] <= wdata;
    end
  end

endmodule

// File: rtl/hsimple_membank.sv
// Single-port memory bank speaking the hsimple four-phase req/ack protocol.
// The bank acknowledges one cycle after a request is first seen, performs a
// write only on the start edge (req high while ack low), and flags
// out-of-range accesses with a one-cycle pulse aligned to the ack rise.
module hsimple_membank
  import hsimple_pkg::*;
#(
  parameter int MEMSIZE = DEF_MEMSIZE,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rwbar,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              oor_err
);

  logic ack_q, ack_d;
  logic oor_err_q, oor_err_d;
  logic start;
  logic we;
  logic in_range;

  hsimple_ram #(
    .MEMSIZE (MEMSIZE),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .in_range (in_range)
  );

  // Start detection and next-state for ack/err; reset low also blocks the
  // write so a transaction caught by reset leaves the array untouched.
  always_comb begin
    start     = req && !ack_q;
    we        = reset && start && (rwbar == WR);
    ack_d     = reset && req;
    oor_err_d = reset && start && !in_range;
  end

  // Handshake and error registers, cleared synchronously while reset is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_q     <= 1'b0;
      oor_err_q <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      oor_err_q <= oor_err_d;
    end
  end

  assign ack     = ack_q;
  assign oor_err = oor_err_q;

endmodule

// File: tb/tb_hsimple_membank.sv
// Scoreboard bench for hsimple_membank: the driver pushes the expected
// response of each transaction, and a negedge monitor pops and compares it
// when ack rises.
module tb_hsimple_membank;
  import hsimple_pkg::*;

  localparam int MS = 200000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        rwbar;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        oor_err;

  always #5 clk = ~clk;

  hsimple_membank #(
    .MEMSIZE (MS),
    .DATA_W  (32),
    .ADDR_W  (32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .rwbar   (rwbar),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ack     (ack),
    .oor_err (oor_err)
  );

  typedef struct {
    logic        is_rd;
    logic [31:0] exp_data;
    logic        exp_oor;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;
  logic        ack_prev = 1'b0;
  logic [31:0] waddr[$];
  logic [31:0] wval[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp_v);
    end
  endtask

  // Monitor: on each ack rise, pop the oldest expectation and compare.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (ack === 1'b1 && ack_prev !== 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack actual=1 expected=0");
        end else begin
          e = sb_q.pop_front();
          if (e.is_rd) check({e.name, "_rdata"}, rdata, e.exp_data);
          check({e.name, "_oor"}, 32'(oor_err), 32'(e.exp_oor));
        end
      end else if (oor_err !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL spurious_oor actual=%b expected=0", oor_err);
      end
      ack_prev = ack;
    end
  end

  // One full handshake: raise req, expect ack one edge later, optionally hold
  // req (with wdata changed to wd2 after ack), drop req, expect ack to fall.
  task automatic xact(input string nm, input logic rd, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] wd2,
                      input logic [31:0] exp_d, input logic exp_oor, input int hold);
    sb_q.push_back('{rd, exp_d, exp_oor, nm});
    req   = 1'b1;
    rwbar = rd;
    addr  = a;
    wdata = wd;
    @(posedge clk); #1;
    check({nm, "_lat"}, 32'(ack), 32'd1);
    wdata = wd2;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({nm, "_held"}, 32'(ack), 32'd1);
    end
    req = 1'b0;
    @(posedge clk); #1;
    check({nm, "_fall"}, 32'(ack), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          j;

    // Reset held low with a write request pending.
    reset = 1'b0;
    req   = 1'b1;
    rwbar = WR;
    addr  = 32'd10;
    wdata = 32'h0A0A_0A0A;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_oor", 32'(oor_err), 32'd0);
    ack_prev = ack;
    mon_en   = 1'b1;
    sb_q.push_back('{WR, 32'h0, 1'b0, "rst_rel"});
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_rel_lat", 32'(ack), 32'd1);
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    xact("rd10", RD, 32'd10, 32'h0, 32'h0, 32'h0A0A_0A0A, 1'b0, 0);

    // Write then read.
    xact("wr5", WR, 32'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    xact("rd5", RD, 32'd5, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

    // Held request: only the start edge writes.
    xact("wr7_held", WR, 32'd7, 32'd1, 32'd2, 32'h0, 1'b0, 4);
    xact("rd7", RD, 32'd7, 32'h0, 32'h0, 32'd1, 1'b0, 0);

    // Boundary addresses.
    xact("wr_top", WR, MS - 1, 32'h1234, 32'h1234, 32'h0, 1'b0, 0);
    xact("rd_top", RD, MS - 1, 32'h0, 32'h0, 32'h1234, 1'b0, 0);
    xact("wr11", WR, 32'd11, 32'h1111_1111, 32'h1111_1111, 32'h0, 1'b0, 0);
    xact("wr_oor", WR, MS, 32'h0BAD_BAD0, 32'h0BAD_BAD0, 32'h0, 1'b1, 0);
    xact("rd_oor", RD, MS, 32'h0, 32'h0, 32'h0, 1'b1, 0);
    xact("wr_oor_alias", WR, 32'd262155, 32'h0000_0BAD, 32'h0000_0BAD, 32'h0, 1'b1, 0);
    xact("rd11", RD, 32'd11, 32'h0, 32'h0, 32'h1111_1111, 1'b0, 0);
    xact("rd_top2", RD, MS - 1, 32'h0, 32'h0, 32'h1234, 1'b0, 0);
    xact("rd5_again", RD, 32'd5, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

    // Reset asserted in the same cycle as a write request.
    xact("wr3", WR, 32'd3, 32'h33, 32'h33, 32'h0, 1'b0, 0);
    reset = 1'b0;
    req   = 1'b1;
    rwbar = WR;
    addr  = 32'd3;
    wdata = 32'h0000_BAD0;
    @(posedge clk); #1;
    check("rst_mid_ack", 32'(ack), 32'd0);
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    xact("rd3", RD, 32'd3, 32'h0, 32'h0, 32'h33, 1'b0, 0);

    // Back-to-back alternating writes and reads over random in-range words.
    for (int i = 0; i < 50; i++) begin
      a = 32'($urandom_range(0, MS - 1));
      d = $urandom;
      xact("b2b_wr", WR, a, d, d, 32'h0, 1'b0, 0);
      for (int k = 0; k < waddr.size(); k++) begin
        if (waddr[k] == a) wval[k] = d;
      end
      waddr.push_back(a);
      wval.push_back(d);
      j = int'($urandom_range(0, waddr.size() - 1));
      xact("b2b_rd", RD, waddr[j], 32'h0, 32'h0, wval[j], 1'b0, 0);
    end

    @(posedge clk); #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
